// File: rtl/reg_bank_store.sv
// 16-entry register bank fed by a one-hot destination decoder, with two registered
// read ports, a sticky one-hot legality flag and a sequenced clear engine.
// Optional build macro: REG_BANK_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_bank_store #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [15:0]      enable,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr_a,
    input  logic [3:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             onehot_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_clr_cnt;
    logic [3:0]              w_clr_cnt_nxt;
    logic [15:0][WIDTH-1:0]  r_regs;
    logic                    w_onehot;
    logic                    w_wr_ok;
    logic [WIDTH-1:0]        w_rd_a;
    logic [WIDTH-1:0]        w_rd_b;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_onehot = (enable != 16'd0) && ((enable & (enable - 16'd1)) == 16'd0);
    assign w_wr_ok  = wr_en && w_onehot && !busy;
    assign busy     = (r_state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clr_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = 4'd0;
                end
            end
            CLEAR: begin
                // clr_req is ignored here; the sweep always runs all 16 entries once.
                w_clr_cnt_nxt = r_clr_cnt + 4'd1;
                if (r_clr_cnt == 4'd15)
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clr_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Clear sweep owns the bank while busy; user writes only land when idle.
    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_regs[gi] <= '0;
            else if (busy && (r_clr_cnt == 4'(gi)))
                r_regs[gi] <= CLR_VALUE;
            else if (w_wr_ok && enable[gi])
                r_regs[gi] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            onehot_err <= 1'b0;
        else if (wr_en && !w_onehot)
            onehot_err <= 1'b1;
    end

`ifdef REG_BANK_BYPASS_EN
    // Forward the in-flight user write; clear-engine writes are never forwarded.
    assign w_rd_a = (w_wr_ok && enable[rd_addr_a]) ? wr_data : r_regs[rd_addr_a];
    assign w_rd_b = (w_wr_ok && enable[rd_addr_b]) ? wr_data : r_regs[rd_addr_b];
`else
    assign w_rd_a = r_regs[rd_addr_a];
    assign w_rd_b = r_regs[rd_addr_b];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= w_rd_a;
            rd_data_b <= w_rd_b;
        end
    end

endmodule

// File: tb/tb_reg_bank_store.sv
// Directed self-checking bench for reg_bank_store (CLR_VALUE chosen non-zero so a
// cleared entry is distinguishable from a reset one).
module tb_reg_bank_store;

    localparam int          WIDTH = 16;
    localparam logic [15:0] CLRV  = 16'h5A3C;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [15:0]      enable;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_addr_a;
    logic [3:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             clr_req;
    logic             busy;
    logic             onehot_err;

    int errs  = 0;
    int total = 0;

    reg_bank_store #(.WIDTH(WIDTH), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .enable(enable), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .clr_req(clr_req), .busy(busy), .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        logic [15:0] one;
        one     = 16'h0001;
        wr_en   = 1'b1;
        enable  = one << idx;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        enable  = 16'h0000;
    endtask

    task automatic rd(input string tag, input int idx, input logic [15:0] exp);
        rd_addr_a = 4'(idx);
        rd_addr_b = 4'(15 - idx);
        tick();
        chk(tag, {16'h0, rd_data_a}, {16'h0, exp});
    endtask

    task automatic rd_all(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(i);
            tick();
            chk({tag, "_a"}, {16'h0, rd_data_a}, {16'h0, exp});
            chk({tag, "_b"}, {16'h0, rd_data_b}, {16'h0, exp});
        end
    endtask

    initial begin
        int bcnt;
        rst = 1'b1; wr_en = 1'b0; enable = 16'h0; wr_data = '0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0; clr_req = 1'b0;
        #12;
        chk("rst_rd_a", {16'h0, rd_data_a}, 32'h0);
        chk("rst_rd_b", {16'h0, rd_data_b}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err",  {31'h0, onehot_err}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Basic write then read one cycle later.
        wr(5, 16'hBEEF);
        rd("wr5_read", 5, 16'hBEEF);

        // Illegal two-hot write must not disturb reg0/reg4 and sets a sticky flag.
        wr(0, 16'h1111);
        wr(4, 16'h4444);
        chk("err_before", {31'h0, onehot_err}, 32'h0);
        wr_en = 1'b1; enable = 16'h0011; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0; enable = 16'h0;
        chk("err_set", {31'h0, onehot_err}, 32'h1);
        rd("twohot_r0", 0, 16'h1111);
        rd("twohot_r4", 4, 16'h4444);
        tick(); tick();
        chk("err_sticky", {31'h0, onehot_err}, 32'h1);

        // Async reset mid-operation.
        rd_addr_a = 4'd5; rd_addr_b = 4'd4;
        tick();
        chk("pre_rst_rd", {16'h0, rd_data_a}, 32'hBEEF);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_a", {16'h0, rd_data_a}, 32'h0);
        chk("arst_rd_b", {16'h0, rd_data_b}, 32'h0);
        chk("arst_err",  {31'h0, onehot_err}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        rd_all("rst_all", 16'h0000);

        // Clear sweep: exactly 16 busy cycles, dropped write, ignored re-request.
        for (int i = 0; i < 16; i++) wr(i, 16'hA5A5);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            bcnt++;
            if (bcnt == 2) begin rd_addr_a = 4'd0; rd_addr_b = 4'd12; end
            if (bcnt == 3) begin
                chk("clr_rd_done", {16'h0, rd_data_a}, {16'h0, CLRV});
                chk("clr_rd_pend", {16'h0, rd_data_b}, 32'hA5A5);
            end
            if (bcnt == 4) clr_req = 1'b1;
            if (bcnt == 5) clr_req = 1'b0;
            if (bcnt == 8) begin wr_en = 1'b1; enable = 16'h0008; wr_data = 16'h1234; end
            if (bcnt == 9) begin wr_en = 1'b0; enable = 16'h0; end
            tick();
        end
        chk("busy_cycles", 32'(bcnt), 32'd16);
        chk("busy_wr_noerr", {31'h0, onehot_err}, 32'h0);
        rd_all("clr_all", CLRV);
        tick();
        chk("idle_after_clr", {31'h0, busy}, 32'h0);

        // Reset at clear cycle 6: abort sweep, bank back to 0, writes work again.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        chk("busy_c6", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wr(9, 16'hCAFE);
        chk("abort_no_resume", {31'h0, busy}, 32'h0);
        rd("post_abort_wr", 9, 16'hCAFE);
        rd("post_abort_r8", 8, 16'h0000);
        rd("post_abort_r2", 2, 16'h0000);
        rd("post_abort_r14", 14, 16'h0000);

        // Same-cycle write and read of reg7.
        wr(7, 16'h1111);
        wr_en = 1'b1; enable = 16'h0080; wr_data = 16'h00FF;
        rd_addr_b = 4'd7; rd_addr_a = 4'd9;
        tick();
        wr_en = 1'b0; enable = 16'h0;
`ifdef REG_BANK_BYPASS_EN
        chk("samecyc_b", {16'h0, rd_data_b}, 32'h00FF);
`else
        chk("samecyc_b", {16'h0, rd_data_b}, 32'h1111);
`endif
        chk("samecyc_a", {16'h0, rd_data_a}, 32'hCAFE);
        tick();
        chk("samecyc_next", {16'h0, rd_data_b}, 32'h00FF);

        // Illegal enable without wr_en is ignored; all-zero enable with wr_en is an error.
        enable = 16'h0011;
        tick();
        chk("noen_noerr", {31'h0, onehot_err}, 32'h0);
        wr_en = 1'b1; enable = 16'h0000; wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("zero_en_err", {31'h0, onehot_err}, 32'h1);
        rd("zero_en_r7", 7, 16'h00FF);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
